// File: rtl/voice_allocator_pkg.sv
// Shared types: MIDI note-change record, plus the voice allocator's table entry,
// voice/FSM state encodings and one-hot priority helpers.
package MIDI;
   localparam int DATA_WIDTH = 7;

   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } note_status_t;

   typedef struct packed {
      note_status_t          status;
      logic [DATA_WIDTH-1:0] note_number;
      logic [DATA_WIDTH-1:0] velocity;
   } note_change_t;
endpackage

package VOICE;
   localparam int MAX_VOICES = 16;
   localparam int AGE_W      = 4;

   typedef logic [MAX_VOICES-1:0] voice_vec_t;

   typedef enum logic [1:0] {
      FREE      = 2'd0,
      HELD      = 2'd1,
      RELEASING = 2'd2
   } voice_state_t;

   typedef struct packed {
      voice_state_t                state;
      logic [MIDI::DATA_WIDTH-1:0] note_number;
      logic [AGE_W-1:0]            age;
   } voice_entry_t;

   typedef enum logic {
      IDLE   = 1'b0,
      DECIDE = 1'b1
   } alloc_state_t;

   function automatic voice_vec_t lowest_onehot(input voice_vec_t vec);
      return vec & (~vec + voice_vec_t'(1'b1));
   endfunction

   function automatic voice_vec_t highest_onehot(input voice_vec_t vec);
      voice_vec_t oh;
      oh = '0;
      for (int i = 0; i < MAX_VOICES; i++) begin
         oh = vec[i] ? (voice_vec_t'(1'b1) << i) : oh;
      end
      return oh;
   endfunction
endpackage

// File: rtl/voice_allocator_note_fifo.sv
// Synchronous first-word-fall-through FIFO of note changes. The parent never
// pushes when full unless it pops in the same cycle, and never pops when empty.
module note_fifo
   import MIDI::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  note_change_t i_data,
   output note_change_t o_data,
   output logic         o_full,
   output logic         o_empty
);
   localparam int PW = $clog2(DEPTH);
   typedef logic [PW:0] ptr_t;

   note_change_t r_mem [DEPTH];
   ptr_t         r_wr_ptr;
   ptr_t         r_rd_ptr;

   // Storage array, written at the write pointer
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr[PW-1:0]] <= i_data;
      end
   end

   // Read/write pointers with a wrap bit to tell full from empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + ptr_t'(1'b1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + ptr_t'(1'b1);
         end
      end
   end

   assign o_data  = r_mem[r_rd_ptr[PW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                    (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: queues note changes and routes each one to a voice
// by retrigger / free / oldest-releasing / oldest-held priority.
module voice_allocator
   import MIDI::*;
   import VOICE::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int FIFO_DEPTH = 4
)
(
   input  logic                            clock_50_000_000,
   input  logic                            reset,
   input  note_change_t                    note,
   input  logic                            note_ready,
   input  logic [NUM_VOICES-1:0]           envelope_end,
   output note_change_t                    voice_note [NUM_VOICES],
   output logic [NUM_VOICES-1:0]           voice_ready,
   output logic [$clog2(NUM_VOICES+1)-1:0] active_voices,
   output logic                            overflow
);
   localparam int CW = $clog2(NUM_VOICES+1);

   alloc_state_t          r_fsm;
   alloc_state_t          w_fsm_next;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_full;
   logic                  w_empty;
   note_change_t          w_fifo_data;
   note_change_t          r_req;

   voice_entry_t          r_table      [NUM_VOICES];
   voice_entry_t          w_next_table [NUM_VOICES];
   note_change_t          r_voice_note [NUM_VOICES];
   logic [NUM_VOICES-1:0] r_voice_ready;
   logic [NUM_VOICES-1:0] w_next_ready;
   logic [CW-1:0]         r_active;
   logic [CW-1:0]         w_next_active;
   logic                  r_overflow;

   voice_vec_t            w_match_vec;
   voice_vec_t            w_free_vec;
   voice_vec_t            w_off_vec;
   voice_vec_t            w_old_vec;
   voice_vec_t            w_rel_rank;
   voice_vec_t            w_rel_top;
   voice_vec_t            w_rel_vec;
   voice_vec_t            w_target_oh;
   logic [AGE_W-1:0]      w_target_age;
   logic                  w_decide;
   logic                  w_is_on;

   // A full FIFO still accepts a push when the same cycle pops an entry
   assign w_push = note_ready & (~w_full | w_pop);

   note_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_note_fifo (
      .clk     (clock_50_000_000),
      .rst     (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (note),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // FSM next state and FIFO pop
   always_comb begin
      w_fsm_next = r_fsm;
      w_pop      = 1'b0;
      case (r_fsm)
         IDLE: begin
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_fsm_next = DECIDE;
            end else begin
               w_fsm_next = IDLE;
            end
         end
         DECIDE: begin
            w_fsm_next = IDLE;
         end
         default: begin
            w_fsm_next = IDLE;
         end
      endcase
   end

   // Target selection; releasing voices are ranked by age so the oldest wins
   always_comb begin
      w_match_vec = '0;
      w_free_vec  = '0;
      w_off_vec   = '0;
      w_old_vec   = '0;
      w_rel_rank  = '0;
      w_rel_vec   = '0;
      w_target_oh = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         w_match_vec[i] = (r_table[i].state != FREE) &&
                          (r_table[i].note_number == r_req.note_number);
         w_free_vec[i]  = (r_table[i].state == FREE);
         w_off_vec[i]   = (r_table[i].state == HELD) &&
                          (r_table[i].note_number == r_req.note_number);
         w_old_vec[i]   = (r_table[i].age == AGE_W'(NUM_VOICES-1));
         w_rel_rank[r_table[i].age] = (r_table[i].state == RELEASING);
      end
      w_rel_top = highest_onehot(w_rel_rank);
      for (int i = 0; i < NUM_VOICES; i++) begin
         w_rel_vec[i] = w_rel_top[r_table[i].age];
      end
      if (r_req.status == ON) begin
         if (|w_match_vec) begin
            w_target_oh = lowest_onehot(w_match_vec);
         end else if (|w_free_vec) begin
            w_target_oh = lowest_onehot(w_free_vec);
         end else if (|w_rel_vec) begin
            w_target_oh = w_rel_vec;
         end else begin
            w_target_oh = w_old_vec;
         end
      end else begin
         w_target_oh = lowest_onehot(w_off_vec);
      end
   end

   // Next voice table, strobes and active count; a DECIDE write beats envelope_end
   always_comb begin
      w_decide      = (r_fsm == DECIDE);
      w_is_on       = (r_req.status == ON);
      w_target_age  = '0;
      w_next_table  = r_table;
      w_next_ready  = '0;
      w_next_active = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         w_target_age = w_target_age | (w_target_oh[i] ? r_table[i].age : '0);
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (w_decide && w_target_oh[i]) begin
            w_next_table[i].state       = w_is_on ? HELD : RELEASING;
            w_next_table[i].note_number = r_req.note_number;
            w_next_ready[i]             = 1'b1;
         end else if (envelope_end[i] && (r_table[i].state == RELEASING)) begin
            w_next_table[i].state = FREE;
         end else begin
            w_next_table[i].state = r_table[i].state;
         end
         if (w_decide && w_is_on) begin
            if (w_target_oh[i]) begin
               w_next_table[i].age = '0;
            end else if (r_table[i].age < w_target_age) begin
               w_next_table[i].age = r_table[i].age + AGE_W'(1'b1);
            end else begin
               w_next_table[i].age = r_table[i].age;
            end
         end else begin
            w_next_table[i].age = r_table[i].age;
         end
         w_next_active = w_next_active + CW'(w_next_table[i].state != FREE);
      end
   end

   // FSM, request register, voice table and registered outputs
   always_ff @(posedge clock_50_000_000 or posedge reset) begin
      if (reset) begin
         r_fsm         <= IDLE;
         r_req         <= '0;
         r_voice_ready <= '0;
         r_active      <= '0;
         r_overflow    <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_table[i].state       <= FREE;
            r_table[i].note_number <= '0;
            r_table[i].age         <= AGE_W'(i);
            r_voice_note[i]        <= '0;
         end
      end else begin
         r_fsm         <= w_fsm_next;
         r_voice_ready <= w_next_ready;
         r_active      <= w_next_active;
         if (w_pop) begin
            r_req <= w_fifo_data;
         end
         if (note_ready && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_table[i] <= w_next_table[i];
            if (w_next_ready[i]) begin
               r_voice_note[i] <= r_req;
            end
         end
      end
   end

   assign voice_note    = r_voice_note;
   assign voice_ready   = r_voice_ready;
   assign active_voices = r_active;
   assign overflow      = r_overflow;
endmodule
